mul_booth_iter: RTL and testbench
=================================

MUL_BOOTH_ITER -- requirements
Module: mul_booth_iter

Interface
REQ-001 Parameter: XLEN, 64, operand width; SHALL be even and at least 8.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  operand request valid.
REQ-005 Port: in_ready  output  1  block can accept a request.
REQ-006 Port: x_signed / y_signed  input  1 each  treat multiplicand / multiplier as signed.
REQ-007 Port: x / y  input  XLEN each  multiplicand / multiplier.
REQ-008 Port: flush  input  1  abort any operation in progress.
REQ-009 Port: out_valid  output  1  result valid.
REQ-010 Port: out_ready  input  1  consumer accepts the result.
REQ-011 Port: result  output  2*XLEN  full product, with result[XLEN-1:0] as the low half.

Function
REQ-012 The FSM SHALL have three states: IDLE, BUSY and DONE.
REQ-013 Transitions: IDLE->BUSY on in_valid&&in_ready; BUSY->DONE after the last iteration; DONE->IDLE on out_ready.
REQ-014 in_ready SHALL equal (state==IDLE); out_valid SHALL equal (state==DONE).
REQ-015 On acceptance, the block SHALL register x, sign- or zero-extended per x_signed to XLEN+1 bits.
REQ-016 On acceptance, the block SHALL load the multiplier shift register as {ext(y) to XLEN+2 bits, 1'b0}, with extension per y_signed.
REQ-017 On acceptance, the accumulator and the iteration counter SHALL be cleared.
REQ-018 Each BUSY cycle SHALL decode the low 3 bits of the shift register with the radix-4 Booth code: 000/111 -> 0; 001/010 -> +X; 011 -> +2X; 100 -> -2X; 101/110 -> -X.
REQ-019 Each partial product SHALL be sign-extended to 2*XLEN, shifted left by 2*iter, and added to the accumulator modulo 2^(2*XLEN).
REQ-020 After each add, the shift register SHALL shift right by 2 with sign fill, and iter SHALL increment.
REQ-021 Iteration count SHALL be (XLEN+2)/2, which is 33 for XLEN=64.
REQ-022 Latency: accept at edge N -> out_valid high after edge N+(XLEN+2)/2.
REQ-023 result SHALL hold the accumulator and stay stable while out_valid && !out_ready (back-pressure).
REQ-024 flush SHALL force IDLE on the next edge from any state and drop out_valid; flush has priority over acceptance in the same cycle.
REQ-025 in_valid while BUSY or DONE SHALL be ignored; a new request is not accepted in the same cycle as DONE->IDLE.

Reset
REQ-026 rst SHALL asynchronously force state=IDLE, accumulator=0, shift register=0, iter=0 and registered x=0.
REQ-027 Reset values: in_ready=1, out_valid=0, result=0; reset mid-operation discards the operation with no output.

Configuration
REQ-028 With MUL_EARLY_EXIT_EN defined: BUSY SHALL go to DONE at the end of any cycle where the post-shift register bits are all 0 or all 1, because the remaining partial products are zero.
REQ-029 With MUL_EARLY_EXIT_EN defined, result SHALL be identical to the full-iteration result.
REQ-030 Without MUL_EARLY_EXIT_EN, latency SHALL always be exactly (XLEN+2)/2 BUSY cycles.

Structure
REQ-031 Shared package mul_pkg SHALL hold: the FSM state enum, the Booth-select struct {neg, zero, one, two}, and the iteration-count constant function.
REQ-032 One sub-module, booth_pp_step, SHALL be used: combinational triplet + X -> signed 2*XLEN partial product.
REQ-033 Sequencing and accumulation SHALL stay in the top module.

Verification
REQ-034 Unsigned x=3, y=5 -> result=15; out_valid exactly 33 cycles after acceptance with the macro off.
REQ-035 Signed x=-1, y=-1 -> result=1; unsigned x=y=0xFFFF_FFFF_FFFF_FFFF -> result=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
REQ-036 Signed x=0x8000_0000_0000_0000, y=-1 -> result=0x0000_0000_0000_0000_8000_0000_0000_0000.
REQ-037 flush at BUSY cycle 10 -> next cycle IDLE, in_ready=1, out_valid never asserted; a following 7*6 request -> result=42.
REQ-038 out_ready held low 5 cycles in DONE -> out_valid and result stable; in_valid ignored until IDLE.
REQ-039 MUL_EARLY_EXIT_EN, unsigned y=2, x=9 -> result=18, out_valid within 2 cycles of acceptance; rst pulsed mid-BUSY -> all outputs at reset values immediately.

Source files
------------

// File: rtl/mul_pkg.sv
// mul_pkg: shared types for the iterative radix-4 Booth multiplier.
// Holds the FSM state enum, the Booth select bundle and the iteration count.
package mul_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef struct packed {
    logic neg;
    logic zero;
    logic one;
    logic two;
  } booth_sel_t;

  // One radix-4 digit per pass over an XLEN+2 bit extended multiplier.
  function automatic int iter_count(input int xlen);
    return (xlen + 2) / 2;
  endfunction

endpackage

// File: rtl/booth_pp_step.sv
// booth_pp_step: radix-4 Booth decode of one multiplier triplet.
// Ports: triplet (3 low shift-register bits), x (XLEN+1 extended
// multiplicand) -> pp (2*XLEN signed partial product, unshifted).
module booth_pp_step
  import mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]        triplet,
  input  logic [XLEN:0]     x,
  output logic [2*XLEN-1:0] pp
);

  booth_sel_t        sel;
  logic [2*XLEN-1:0] x_ext;
  logic [2*XLEN-1:0] mag;

  always_comb begin
    sel = '0;
    unique case (triplet)
      3'b000, 3'b111: sel.zero = 1'b1;
      3'b001, 3'b010: sel.one  = 1'b1;
      3'b011: sel.two = 1'b1;
      3'b100: begin
        sel.neg = 1'b1;
        sel.two = 1'b1;
      end
      3'b101, 3'b110: begin
        sel.neg = 1'b1;
        sel.one = 1'b1;
      end
    endcase
  end

  assign x_ext = {{(XLEN-1){x[XLEN]}}, x};

  always_comb begin
    mag = '0;
    unique case (1'b1)
      sel.zero: mag = '0;
      sel.two:  mag = x_ext << 1;
      sel.one:  mag = x_ext;
      default:  mag = '0;
    endcase
  end

  assign pp = sel.neg ? -mag : mag;

endmodule

// File: rtl/mul_booth_iter.sv
// mul_booth_iter: iterative radix-4 Booth multiplier, one digit per cycle.
// Ports: clk, rst (async high); in_valid/in_ready, x/y, x_signed/y_signed
// request side; out_valid/out_ready, result (2*XLEN) response side; flush
// aborts. Define MUL_EARLY_EXIT_EN to finish once remaining digits are zero.
module mul_booth_iter
  import mul_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                x_signed,
  input  logic                y_signed,
  input  logic [XLEN-1:0]     x,
  input  logic [XLEN-1:0]     y,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [2*XLEN-1:0]   result
);

  localparam int ITERS = iter_count(XLEN);
  localparam int IW    = $clog2(ITERS + 1);
  localparam int SW    = XLEN + 3;

  state_t            state;
  logic [XLEN:0]     xr;
  logic [SW-1:0]     sr;
  logic [SW-1:0]     sr_nxt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] pp;
  logic [2*XLEN-1:0] pp_sh;
  logic [IW-1:0]     iter;
  logic              last;
  logic [XLEN:0]     x_ext;
  logic [XLEN+1:0]   y_ext;

  booth_pp_step #(
    .XLEN(XLEN)
  ) u_pp (
    .triplet(sr[2:0]),
    .x      (xr),
    .pp     (pp)
  );

  assign x_ext  = {x_signed & x[XLEN-1], x};
  assign y_ext  = {{2{y_signed & y[XLEN-1]}}, y};
  assign sr_nxt = {{2{sr[SW-1]}}, sr[SW-1:2]};
  assign pp_sh  = pp << {iter, 1'b0};

  // A shifted register of all 0s or all 1s only yields zero digits.
  always_comb begin
    last = (iter == IW'(ITERS - 1));
`ifdef MUL_EARLY_EXIT_EN
    last = last | (&sr_nxt) | ~(|sr_nxt);
`else
    last = last;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      xr    <= '0;
      sr    <= '0;
      acc   <= '0;
      iter  <= '0;
    end else if (flush) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            state <= BUSY;
            xr    <= x_ext;
            sr    <= {y_ext, 1'b0};
            acc   <= '0;
            iter  <= '0;
          end
        end
        BUSY: begin
          acc  <= acc + pp_sh;
          sr   <= sr_nxt;
          iter <= iter + 1'b1;
          if (last) state <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign result    = acc;

endmodule

// File: tb/tb_mul_booth_iter.sv
// tb_mul_booth_iter: directed and random checks of mul_booth_iter.
// Products are compared against plain wide signed multiplication.
module tb_mul_booth_iter;

  localparam int XLEN  = 64;
  localparam int ITERS = 33;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic         x_signed;
  logic         y_signed;
  logic [63:0]  x;
  logic [63:0]  y;
  logic         flush;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] result;

  int errors;
  int checks;

  mul_booth_iter #(
    .XLEN(XLEN)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .x_signed (x_signed),
    .y_signed (y_signed),
    .x        (x),
    .y        (y),
    .flush    (flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [127:0] ref_mul(
    input logic [63:0] a,
    input logic [63:0] b,
    input logic        sa,
    input logic        sb
  );
    logic signed [129:0] ea;
    logic signed [129:0] eb;
    logic signed [129:0] p;
    ea = {{66{sa & a[63]}}, a};
    eb = {{66{sb & b[63]}}, b};
    p  = ea * eb;
    return p[127:0];
  endfunction

  task automatic chk(
    input string        tag,
    input logic [127:0] obs,
    input logic [127:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic lat_chk(input string tag, input int lat);
`ifdef MUL_EARLY_EXIT_EN
    chk(tag, 128'(lat >= 1 && lat <= ITERS), 128'd1);
`else
    chk(tag, 128'(lat), 128'(ITERS));
`endif
  endtask

  // Issue one request, wait for the result, hold it under back-pressure.
  task automatic run_op(
    input  logic [63:0]  a,
    input  logic [63:0]  b,
    input  logic         sa,
    input  logic         sb,
    input  int           hold,
    output int           lat,
    output logic [127:0] res
  );
    logic [127:0] held;
    x = a;
    y = b;
    x_signed = sa;
    y_signed = sb;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!out_valid) begin
      chk("timeout", 128'd0, 128'd1);
      res = '0;
      return;
    end
    res  = result;
    held = result;
    in_valid = 1'b1;
    x = ~a;
    repeat (hold) begin
      @(posedge clk);
      #1;
      chk("bp_out_valid", 128'(out_valid), 128'd1);
      chk("bp_result", result, held);
      chk("bp_in_ready", 128'(in_ready), 128'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("idle_in_ready", 128'(in_ready), 128'd1);
    chk("idle_out_valid", 128'(out_valid), 128'd0);
  endtask

  initial begin
    int           lat;
    logic [127:0] res;
    logic [63:0]  ra;
    logic [63:0]  rb;
    logic         rsa;
    logic         rsb;
    logic         seen;

    errors    = 0;
    checks    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    x_signed  = 1'b0;
    y_signed  = 1'b0;
    x         = '0;
    y         = '0;
    flush     = 1'b0;
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'd1);
    chk("rst_out_valid", 128'(out_valid), 128'd0);
    chk("rst_result", result, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    run_op(64'd3, 64'd5, 1'b0, 1'b0, 0, lat, res);
    chk("u3x5", res, 128'd15);
    lat_chk("u3x5_lat", lat);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           1'b1, 1'b1, 0, lat, res);
    chk("sm1xm1", res, 128'd1);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
           1'b0, 1'b0, 0, lat, res);
    chk("umax", res, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);

    run_op(64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
           1'b1, 1'b1, 0, lat, res);
    chk("smin_xm1", res, 128'h0000_0000_0000_0000_8000_0000_0000_0000);

    run_op(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000,
           1'b1, 1'b0, 0, lat, res);
    chk("smin_x_u2p63", res, 128'hC000_0000_0000_0000_0000_0000_0000_0000);

    // Flush in the 10th busy cycle.
    x = 64'h1234_5678_9ABC_DEF0;
    y = 64'h0FED_CBA9_8765_4321;
    x_signed = 1'b0;
    y_signed = 1'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", 128'(in_ready), 128'd1);
    chk("flush_out_valid", 128'(out_valid), 128'd0);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("flush_no_valid", 128'(seen), 128'd0);

    // Flush wins over a same-cycle request.
    in_valid = 1'b1;
    flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush = 1'b0;
    chk("flush_prio", 128'(in_ready), 128'd1);

    run_op(64'd7, 64'd6, 1'b0, 1'b0, 0, lat, res);
    chk("u7x6", res, 128'd42);

    run_op(64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFD,
           1'b1, 1'b1, 5, lat, res);
    chk("bp_prod", res,
        ref_mul(64'hDEAD_BEEF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFD, 1'b1, 1'b1));

    run_op(64'd9, 64'd2, 1'b0, 1'b0, 0, lat, res);
    chk("u9x2", res, 128'd18);
`ifdef MUL_EARLY_EXIT_EN
    chk("u9x2_lat", 128'(lat <= 2), 128'd1);
`else
    chk("u9x2_lat", 128'(lat), 128'(ITERS));
`endif

    for (int i = 0; i < 24; i++) begin
      ra  = {$urandom, $urandom};
      rb  = {$urandom, $urandom};
      rsa = 1'($urandom);
      rsb = 1'($urandom);
      if (i % 6 == 1) rb = 64'($urandom_range(0, 7));
      if (i % 6 == 2) rb = ~64'($urandom_range(0, 7));
      run_op(ra, rb, rsa, rsb, i % 3, lat, res);
      chk("rand_prod", res, ref_mul(ra, rb, rsa, rsb));
      lat_chk("rand_lat", lat);
    end

    // Reset in the middle of an operation.
    x = 64'hFFFF_0000_FFFF_0000;
    y = 64'h0123_4567_89AB_CDEF;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    chk("mid_rst_in_ready", 128'(in_ready), 128'd1);
    chk("mid_rst_out_valid", 128'(out_valid), 128'd0);
    chk("mid_rst_result", result, 128'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    chk("mid_rst_no_valid", 128'(seen), 128'd0);

    run_op(64'd11, 64'd13, 1'b0, 1'b0, 0, lat, res);
    chk("post_rst", res, 128'd143);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
